// File: rtl/conv_frame_ctrl.sv
// Streaming frame controller for strided KxK convolution over IMG_W x IMG_H frames.
// Optional macro CONV_FRAME_FLAGS_EN adds eol_o/eof_o end-of-row/end-of-frame flags.

module conv_core #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16,
  parameter int Q          = 5,
  parameter int K_SIZE     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] pix,
  output logic signed [DATA_WIDTH-1:0] res
);
  // Unity box kernel in Q format; history spans K-1 full lines plus K-1 pixels.
  localparam int DEPTH = (K_SIZE - 1) * N + K_SIZE - 1;
  localparam int AW    = 2 * DATA_WIDTH + 8;
  localparam logic signed [AW-1:0] COEF = AW'(2 ** Q);

  logic signed [DATA_WIDTH-1:0] hist [DEPTH];
  logic signed [DATA_WIDTH-1:0] line [DEPTH+1];
  logic signed [AW-1:0]         acc;
  logic signed [AW-1:0]         scaled;

  always_comb begin
    line[0] = pix;
    for (int i = 0; i < DEPTH; i++) line[i+1] = hist[i];
  end

  always_comb begin
    acc = '0;
    for (int r = 0; r < K_SIZE; r++)
      for (int c = 0; c < K_SIZE; c++)
        acc = acc + AW'(line[r*N + c]) * COEF;
  end

  assign scaled = acc >>> Q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      res <= '0;
    end else if (en) begin
      hist[0] <= pix;
      for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
      res <= scaled[DATA_WIDTH-1:0];
    end
  end
endmodule

// state | meaning
// IDLE  | waiting for start_i
// RUN   | accepting pixels, tracking position and stride phase
// DONE  | one-cycle done_o pulse, then back to IDLE
module conv_frame_ctrl #(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int DATA_WIDTH = 16,
  parameter int Q          = 5,
  parameter int K_SIZE     = 3,
  parameter int STRIDE     = 1,
  parameter int CW         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic [CW-1:0]         out_col_o,
  output logic [CW-1:0]         out_row_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
`ifdef CONV_FRAME_FLAGS_EN
  ,
  output logic                  eol_o,
  output logic                  eof_o
`endif
);
  localparam logic [CW-1:0] KM1      = CW'(K_SIZE - 1);
  localparam logic [CW-1:0] SM1      = CW'(STRIDE - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);
`ifdef CONV_FRAME_FLAGS_EN
  localparam logic [CW-1:0] OW_M1 = CW'((IMG_W - K_SIZE) / STRIDE);
  localparam logic [CW-1:0] OH_M1 = CW'((IMG_H - K_SIZE) / STRIDE);
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;

  logic [CW-1:0] col, row, col_ph, row_ph, ocol, orow;
  logic accept, row_hit, col_hit, hit;

  assign accept  = valid_i & ready_o;
  assign row_hit = (row >= KM1) && (row_ph == '0);
  assign col_hit = (col >= KM1) && (col_ph == '0);
  assign hit     = row_hit & col_hit;

  // Phase restarts at the first window-aligned position and then cycles with the stride.
  function automatic logic [CW-1:0] next_ph(input logic [CW-1:0] pos_next, input logic [CW-1:0] ph);
    if (pos_next == KM1) return '0;
    else if (ph == '0)   return SM1;
    else                 return ph - CW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      col_ph    <= '0;
      row_ph    <= '0;
      ocol      <= '0;
      orow      <= '0;
      ready_o   <= 1'b0;
      valid_o   <= 1'b0;
      out_col_o <= '0;
      out_row_o <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
`ifdef CONV_FRAME_FLAGS_EN
      eol_o     <= 1'b0;
      eof_o     <= 1'b0;
`endif
    end else begin
      valid_o <= 1'b0;
`ifdef CONV_FRAME_FLAGS_EN
      eol_o   <= 1'b0;
      eof_o   <= 1'b0;
`endif
      if (start_i && state != IDLE) err_o <= 1'b1;
      case (state)
        IDLE: if (start_i) begin
          state   <= RUN;
          ready_o <= 1'b1;
          busy_o  <= 1'b1;
          col     <= '0;
          row     <= '0;
          col_ph  <= '0;
          row_ph  <= '0;
          ocol    <= '0;
          orow    <= '0;
        end
        RUN: if (accept) begin
          if (hit) begin
            valid_o   <= 1'b1;
            out_col_o <= ocol;
            out_row_o <= orow;
            ocol      <= ocol + CW'(1);
`ifdef CONV_FRAME_FLAGS_EN
            eol_o     <= (ocol == OW_M1);
            eof_o     <= (ocol == OW_M1) && (orow == OH_M1);
`endif
          end
          if (col == LAST_COL) begin
            col    <= '0;
            col_ph <= '0;
            ocol   <= '0;
            row    <= row + CW'(1);
            row_ph <= next_ph(row + CW'(1), row_ph);
            if (row_hit) orow <= orow + CW'(1);
            if (row == LAST_ROW) begin
              state   <= DONE;
              ready_o <= 1'b0;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
            end
          end else begin
            col    <= col + CW'(1);
            col_ph <= next_ph(col + CW'(1), col_ph);
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  conv_core #(
    .N(IMG_W), .DATA_WIDTH(DATA_WIDTH), .Q(Q), .K_SIZE(K_SIZE)
  ) u_conv (
    .clk(clk),
    .rst(rst),
    .en(accept),
    .pix(data_i),
    .res(data_o)
  );
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench: 6x5 stride-1 and 8x6 stride-2 instances driven in turn from one stream.
module tb_conv_frame_ctrl;
  localparam int DW = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b, valid;
  logic [DW-1:0] data;

  logic a_ready, a_valid, a_busy, a_done, a_err;
  logic b_ready, b_valid, b_busy, b_done, b_err;
  logic [DW-1:0] a_data, b_data;
  logic [CW-1:0] a_col, a_row, b_col, b_row;
`ifdef CONV_FRAME_FLAGS_EN
  logic a_eol, a_eof, b_eol, b_eof;
`endif

  conv_frame_ctrl #(.IMG_W(6), .IMG_H(5), .DATA_WIDTH(DW), .Q(5), .K_SIZE(3), .STRIDE(1), .CW(CW)) u_dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .data_i(data), .valid_i(valid), .ready_o(a_ready),
    .data_o(a_data), .valid_o(a_valid), .out_col_o(a_col), .out_row_o(a_row), .busy_o(a_busy),
    .done_o(a_done), .err_o(a_err)
`ifdef CONV_FRAME_FLAGS_EN
    , .eol_o(a_eol), .eof_o(a_eof)
`endif
  );

  conv_frame_ctrl #(.IMG_W(8), .IMG_H(6), .DATA_WIDTH(DW), .Q(5), .K_SIZE(3), .STRIDE(2), .CW(CW)) u_dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .data_i(data), .valid_i(valid), .ready_o(b_ready),
    .data_o(b_data), .valid_o(b_valid), .out_col_o(b_col), .out_row_o(b_row), .busy_o(b_busy),
    .done_o(b_done), .err_o(b_err)
`ifdef CONV_FRAME_FLAGS_EN
    , .eol_o(b_eol), .eof_o(b_eof)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          eol;
    logic          eof;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int checks = 0;
  int errors = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int img [0:7][0:7];
  bit exp_err_a = 1'b0;
  bit exp_err_b = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_valid) begin
      pulses_a++;
      if (qa.size() == 0) check("a_unexpected_valid", a_valid, 0);
      else begin
        ea = qa.pop_front();
        check("a_data", a_data, ea.data);
        check("a_col", a_col, ea.col);
        check("a_row", a_row, ea.row);
`ifdef CONV_FRAME_FLAGS_EN
        check("a_eol", a_eol, ea.eol);
        check("a_eof", a_eof, ea.eof);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (b_valid) begin
      pulses_b++;
      if (qb.size() == 0) check("b_unexpected_valid", b_valid, 0);
      else begin
        eb = qb.pop_front();
        check("b_data", b_data, eb.data);
        check("b_col", b_col, eb.col);
        check("b_row", b_row, eb.row);
`ifdef CONV_FRAME_FLAGS_EN
        check("b_eol", b_eol, eb.eol);
        check("b_eof", b_eof, eb.eof);
`endif
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rst_ready_a"}, a_ready, 0);
    check({tag, "_rst_valid_a"}, a_valid, 0);
    check({tag, "_rst_busy_a"}, a_busy, 0);
    check({tag, "_rst_done_a"}, a_done, 0);
    check({tag, "_rst_err_a"}, a_err, 0);
    check({tag, "_rst_data_a"}, a_data, 0);
    check({tag, "_rst_col_a"}, a_col, 0);
    check({tag, "_rst_row_a"}, a_row, 0);
    check({tag, "_rst_ready_b"}, b_ready, 0);
    check({tag, "_rst_busy_b"}, b_busy, 0);
    check({tag, "_rst_err_b"}, b_err, 0);
  endtask

  task automatic run_frame(input bit sel, input int w, input int h, input int s, input int idle_pct,
                           input int err_at, input int rst_at, input bit done_start);
    int ow, oh, p, budget, r, c, sum, exp_cnt;
    exp_t e;
    ow = (w - 3) / s + 1;
    oh = (h - 3) / s + 1;
    p = 0;
    budget = 0;
    exp_cnt = 0;
    if (sel) pulses_b = 0; else pulses_a = 0;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    while (p < w * h) begin
      budget++;
      if (budget > 4000) begin
        check("frame_timeout", budget, 0);
        break;
      end
      check("ready_in_run", sel ? b_ready : a_ready, 1);
      check("busy_in_run", sel ? b_busy : a_busy, 1);
      check("done_in_run", sel ? b_done : a_done, 0);
      start_a = 1'b0;
      start_b = 1'b0;
      if (p == rst_at) begin
        valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid");
        rst = 1'b0;
        exp_err_a = 1'b0;
        exp_err_b = 1'b0;
        qa.delete();
        qb.delete();
        return;
      end
      if (p == err_at) begin
        if (sel) begin start_b = 1'b1; exp_err_b = 1'b1; end
        else     begin start_a = 1'b1; exp_err_a = 1'b1; end
      end
      if ($urandom_range(0, 99) < idle_pct) begin
        valid = 1'b0;
        data = DW'($urandom);
      end else begin
        r = p / w;
        c = p % w;
        img[r][c] = int'($urandom_range(0, 1000)) - 500;
        data = DW'(img[r][c]);
        valid = 1'b1;
        if (r >= 2 && c >= 2 && (r - 2) % s == 0 && (c - 2) % s == 0) begin
          sum = 0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              sum += img[r-i][c-j];
          e.data = DW'(sum);
          e.col  = CW'((c - 2) / s);
          e.row  = CW'((r - 2) / s);
          e.eol  = ((c - 2) / s == ow - 1);
          e.eof  = e.eol && ((r - 2) / s == oh - 1);
          if (sel) qb.push_back(e); else qa.push_back(e);
          exp_cnt++;
        end
        p++;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    check("done_pulse", sel ? b_done : a_done, 1);
    check("busy_in_done", sel ? b_busy : a_busy, 0);
    check("ready_in_done", sel ? b_ready : a_ready, 0);
    if (done_start) begin
      if (sel) begin start_b = 1'b1; exp_err_b = 1'b1; end
      else     begin start_a = 1'b1; exp_err_a = 1'b1; end
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check("done_cleared", sel ? b_done : a_done, 0);
    check("ready_idle", sel ? b_ready : a_ready, 0);
    @(negedge clk);
    check("ready_stays_idle", sel ? b_ready : a_ready, 0);
    check("err_flag", sel ? b_err : a_err, sel ? exp_err_b : exp_err_a);
    check("valid_count", sel ? pulses_b : pulses_a, exp_cnt);
    check("queue_drained", sel ? qb.size() : qa.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    valid = 1'b0;
    data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("init");
    rst = 1'b0;
    @(negedge clk);

    run_frame(1'b0, 6, 5, 1, 0, -1, -1, 1'b0);
    run_frame(1'b0, 6, 5, 1, 40, -1, -1, 1'b0);
    run_frame(1'b1, 8, 6, 2, 0, -1, -1, 1'b0);
    run_frame(1'b1, 8, 6, 2, 40, -1, -1, 1'b1);
    run_frame(1'b0, 6, 5, 1, 20, 7, -1, 1'b0);
    run_frame(1'b0, 6, 5, 1, 0, -1, 10, 1'b0);

    valid = 1'b1;
    data = 16'h0123;
    repeat (3) begin
      @(negedge clk);
      check("no_frame_without_start", a_ready, 0);
    end
    valid = 1'b0;

    run_frame(1'b0, 6, 5, 1, 0, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_frame_ctrl.md
Name: conv_frame_ctrl

Overview:
Streaming frame controller for 2-D convolution over non-square images with configurable stride. It accepts one pixel per cycle under a valid/ready handshake and drives an internal convolutor instance (N=IMG_W). It tracks row/column position, flags which convolutor results are genuine stride-aligned output pixels, reports output coordinates, and signals frame completion. It replaces the square-only, stride-1 top-level used today.

Parameters:
IMG_W, 8, image width in pixels (>= K_SIZE)
IMG_H, 8, image height in pixels (>= K_SIZE)
DATA_WIDTH, 16, pixel/result width, signed fixed point
Q, 5, fractional bits, passed to convolutor
K_SIZE, 3, kernel edge length
STRIDE, 1, output stride in both axes (>= 1)
CW, 16, width of coordinate/counter fields

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start_i  in  1  pulse in IDLE begins a frame
data_i  in  DATA_WIDTH  input pixel, raster order
valid_i  in  1  data_i valid
ready_o  out  1  block accepts a pixel this cycle
data_o  out  DATA_WIDTH  convolution result (convolutor output)
valid_o  out  1  data_o is a real output pixel
out_col_o  out  CW  output column index of data_o
out_row_o  out  CW  output row index of data_o
busy_o  out  1  frame in progress
done_o  out  1  one-cycle pulse after last pixel accepted
err_o  out  1  sticky: start_i seen while busy

Behaviour:
- Reset: state IDLE, all counters 0; ready_o, valid_o, busy_o, done_o, err_o = 0; out_col_o/out_row_o = 0.
- Accept = valid_i & ready_o. ready_o = 1 only in RUN. Convolutor en = accept. Convolutor output is valid the cycle after accept.
- States:
  - IDLE: start_i -> RUN.
  - RUN: busy_o=1. Each accept advances col (0..IMG_W-1); on wrap, row advances. Accepting (IMG_H-1, IMG_W-1) -> DONE.
  - DONE: done_o=1, busy_o=0, ready_o=0 for one cycle; then -> IDLE.
- Output flag: valid_o is registered and asserted the cycle after accepting a pixel at (row,col) when all of these hold:
  - row >= K_SIZE-1 and col >= K_SIZE-1;
  - (row-(K_SIZE-1)) mod STRIDE == 0;
  - (col-(K_SIZE-1)) mod STRIDE == 0.
  - Otherwise valid_o=0. It is also 0 in any cycle with no accept the cycle before.
- Stride alignment uses phase counters reloaded at K_SIZE-1 and at row wrap. No divider.
- Output counts:
  - OUT_W = floor((IMG_W-K_SIZE)/STRIDE)+1; OUT_H likewise.
  - Trailing columns/rows beyond the last full stride produce no output.
- out_col_o/out_row_o update together with valid_o (0..OUT_W-1, 0..OUT_H-1). They hold their value when valid_o=0.
- Stalls: gaps in valid_i freeze all counters and the convolutor; no output is lost or duplicated.
- start_i in RUN or DONE: ignored for frame control; sets err_o. err_o clears only on rst.
- start_i coinciding with the DONE cycle: ignored, err_o set.
- rst mid-frame: immediate return to reset values; the next frame needs a new start_i.
- Counters are CW bits; IMG_W, IMG_H < 2^CW is required.

Optional Feature:
- Macro CONV_FRAME_FLAGS_EN.
- Defined: adds outputs eol_o and eof_o, both registered alongside valid_o.
  - eol_o=1 with the last output of each output row (out_col_o==OUT_W-1).
  - eof_o=1 with the final output of the frame.
- Undefined: these ports are absent. No other behaviour changes.

Test Plan:
- IMG_W=6, IMG_H=5, K=3, S=1, continuous valid_i -> exactly 12 valid_o pulses. First pulse follows accept of pixel index 14 (row 2, col 2) with coords (0,0). Last pulse has coords (3,2). done_o fires one cycle after pixel 29 is accepted.
- IMG_W=7, IMG_H=7, K=3, S=2 -> 9 outputs, from accepted pixels (2,2),(2,4),(2,6),(4,2)…(6,6). Coords run (0..2, 0..2). Results match a software reference convolution.
- IMG_W=8, IMG_H=6, K=3, S=2 -> OUT_W=3, OUT_H=2. Column 7 and row 5 produce no valid_o.
- Random valid_i gaps (~40% idle), same config as test 1 -> identical data/coord sequence. ready_o stays 1 throughout RUN.
- start_i pulsed mid-frame -> err_o=1 and stays set; frame completes normally. rst at pixel 10 -> all outputs 0 next cycle. A new start_i then processes a full clean frame.
- With CONV_FRAME_FLAGS_EN and config 1 -> eol_o at coords (3,0),(3,1),(3,2). eof_o only at (3,2).
